// File: rtl/register_window_file_pkg.sv
// Shared constants for the SPARC windowed register file.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
package sparc_rf_pkg;

  localparam int RF_GLOBALS   = 8;
  localparam int RF_WINREGS   = 16;
  localparam int OUT_BASE     = 8;
  localparam int LOC_BASE     = 16;
  localparam int IN_BASE      = 24;
  localparam int RF_NWIN_DEF  = 8;
  localparam int RF_DATA_W    = 32;

  // Number of physical registers backing NWIN windows plus the globals.
  function automatic int rf_phys_regs(input int nwin);
    return RF_GLOBALS + nwin * RF_WINREGS;
  endfunction

endpackage

// File: rtl/register_window_file_if.sv
// Bus bundle between decode/writeback and the windowed register file.
interface register_window_file_if #(
  parameter int NWIN = 8,
  parameter int CWPW = 5
) ();

  logic [4:0]      RaA;
  logic [4:0]      RaB;
  logic [31:0]     QA;
  logic [31:0]     QB;
  logic [4:0]      Wa;
  logic [31:0]     D;
  logic            Le;
  logic            Save;
  logic            Restore;
  logic [CWPW-1:0] CwpD;
  logic            CwpLe;
  logic [NWIN-1:0] WimD;
  logic            WimLe;
  logic [CWPW-1:0] Cwp;
  logic [NWIN-1:0] Wim;
  logic            WinOvf;
  logic            WinUnf;

  modport master (
    output RaA, RaB, Wa, D, Le, Save, Restore, CwpD, CwpLe, WimD, WimLe,
    input  QA, QB, Cwp, Wim, WinOvf, WinUnf
  );

  modport slave (
    input  RaA, RaB, Wa, D, Le, Save, Restore, CwpD, CwpLe, WimD, WimLe,
    output QA, QB, Cwp, Wim, WinOvf, WinUnf
  );

endinterface

// File: rtl/register_window_file_rf_window_map.sv
// Logical register number + current window -> physical storage index.
// r0 is flagged through o_zero; its physical index is a don't-care (0).
module rf_window_map
  import sparc_rf_pkg::*;
#(
  parameter int NWIN = 8,
  parameter int CWPW = 5,
  parameter int PW   = 8
) (
  input  logic [4:0]      i_addr,
  input  logic [CWPW-1:0] i_cwp,
  output logic [PW-1:0]   o_phys,
  output logic            o_zero
);

  int w_addr;
  int w_win;
  int w_nxt;
  int w_idx;

  // Classify the register and add the window base; ins live in the next window's outs.
  always_comb begin
    w_addr = int'(i_addr);
    w_win  = int'(i_cwp);
    w_nxt  = (w_win == NWIN - 1) ? 0 : w_win + 1;
    w_idx  = 0;
    o_zero = (w_addr == 0);
    if (w_addr == 0)
      w_idx = 0;
    else if (w_addr < OUT_BASE)
      w_idx = w_addr - 1;
    else if (w_addr < LOC_BASE)
      w_idx = RF_GLOBALS + w_win * RF_WINREGS + (w_addr - OUT_BASE);
    else if (w_addr < IN_BASE)
      w_idx = RF_GLOBALS + w_win * RF_WINREGS + 8 + (w_addr - LOC_BASE);
    else
      w_idx = RF_GLOBALS + w_nxt * RF_WINREGS + (w_addr - IN_BASE);
    o_phys = PW'(w_idx);
  end

endmodule

// File: rtl/register_window_file.sv
// SPARC windowed integer register file: storage, CWP/WIM state, SAVE/RESTORE
// sequencing with overflow/underflow traps.
// Build option: RF_BYPASS_EN forwards same-cycle write data to the read ports.
module register_window_file
  import sparc_rf_pkg::*;
#(
  parameter int NWIN = RF_NWIN_DEF,
  parameter int CWPW = 5
) (
  input  logic Clk,
  input  logic Clr,
  register_window_file_if.slave bus
);

  localparam int NPHYS = rf_phys_regs(NWIN);
  localparam int PW    = $clog2(NPHYS);

  logic [RF_DATA_W-1:0] r_mem [NPHYS];
  logic [CWPW-1:0]      r_cwp;
  logic [NWIN-1:0]      r_wim;
  logic                 r_ovf;
  logic                 r_unf;

  logic [PW-1:0]        w_pa, w_pb, w_pw;
  logic                 w_za, w_zb, w_zw;
  logic [CWPW-1:0]      w_cwp_dn, w_cwp_up, w_cwp_ld;
  logic                 w_wim_dn, w_wim_up;
  logic [RF_DATA_W-1:0] w_qa, w_qb;

  function automatic logic [CWPW-1:0] cwp_dec(input logic [CWPW-1:0] c);
    return (c == '0) ? CWPW'(NWIN - 1) : c - CWPW'(1);
  endfunction

  function automatic logic [CWPW-1:0] cwp_inc(input logic [CWPW-1:0] c);
    return (c == CWPW'(NWIN - 1)) ? '0 : c + CWPW'(1);
  endfunction

  function automatic logic [CWPW-1:0] cwp_mod(input logic [CWPW-1:0] c);
    return CWPW'(int'(c) % NWIN);
  endfunction

  rf_window_map #(.NWIN(NWIN), .CWPW(CWPW), .PW(PW)) u_map_a (
    .i_addr(bus.RaA), .i_cwp(r_cwp), .o_phys(w_pa), .o_zero(w_za)
  );

  rf_window_map #(.NWIN(NWIN), .CWPW(CWPW), .PW(PW)) u_map_b (
    .i_addr(bus.RaB), .i_cwp(r_cwp), .o_phys(w_pb), .o_zero(w_zb)
  );

  rf_window_map #(.NWIN(NWIN), .CWPW(CWPW), .PW(PW)) u_map_w (
    .i_addr(bus.Wa), .i_cwp(r_cwp), .o_phys(w_pw), .o_zero(w_zw)
  );

  assign w_cwp_dn = cwp_dec(r_cwp);
  assign w_cwp_up = cwp_inc(r_cwp);
  assign w_cwp_ld = cwp_mod(bus.CwpD);
  assign w_wim_dn = |(r_wim & (NWIN'(1) << w_cwp_dn));
  assign w_wim_up = |(r_wim & (NWIN'(1) << w_cwp_up));

  // Read ports: r0 is hardwired zero, optional forwarding of the in-flight write.
  always_comb begin
    w_qa = w_za ? '0 : r_mem[w_pa];
    w_qb = w_zb ? '0 : r_mem[w_pb];
`ifdef RF_BYPASS_EN
    if (bus.Le && !w_zw && !w_za && (w_pa == w_pw)) w_qa = bus.D;
    if (bus.Le && !w_zw && !w_zb && (w_pb == w_pw)) w_qb = bus.D;
`endif
  end

  assign bus.QA     = w_qa;
  assign bus.QB     = w_qb;
  assign bus.Cwp    = r_cwp;
  assign bus.Wim    = r_wim;
  assign bus.WinOvf = r_ovf;
  assign bus.WinUnf = r_unf;

  // Register storage write through the pre-edge window; reset clears everything.
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      for (int i = 0; i < NPHYS; i++) r_mem[i] <= '0;
    end else if (bus.Le && !w_zw) begin
      r_mem[w_pw] <= bus.D;
    end
  end

  // Window pointer, invalid mask and trap pulses; CWP load beats SAVE/RESTORE.
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      r_cwp <= '0;
      r_wim <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      if (bus.WimLe) r_wim <= bus.WimD;
      if (bus.CwpLe) begin
        r_cwp <= w_cwp_ld;
      end else if (bus.Save && !bus.Restore) begin
        if (w_wim_dn) r_ovf <= 1'b1;
        else          r_cwp <= w_cwp_dn;
      end else if (bus.Restore && !bus.Save) begin
        if (w_wim_up) r_unf <= 1'b1;
        else          r_cwp <= w_cwp_up;
      end
    end
  end

endmodule
